lfsr_stream_scrambler: RTL and testbench

- Parametrised, registered successor to our combinational parallel LFSR scrambler.
- Each accepted beat advances a STATE_W-bit Galois LFSR by DATA_W serial steps and produces DATA_W output bits.
- The polynomial is set by parameter; the mode (multiplicative scramble, descramble, additive) is selected per beat.
- Sits on the streaming datapath between framer and serializer, with valid/ready handshake and runtime seed load.

---
 rtl/lfsr_stream_scrambler_if.sv | 45 ++++
 rtl/lfsr_stream_scrambler.sv | 82 ++++++++
 tb/tb_lfsr_stream_scrambler.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_stream_scrambler_if.sv
// Handshake, seed-load and status bundle between a stream source/sink and lfsr_stream_scrambler.
interface lfsr_stream_scrambler_if #(
   parameter int STATE_W = 347,
   parameter int DATA_W  = 11
);
   logic               seed_load;
   logic [STATE_W-1:0] seed_value;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         mode;
   logic [DATA_W-1:0]  din;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  dout;
   logic [STATE_W-1:0] state_out;
   logic [31:0]        beat_cnt;

   modport master (
      output seed_load,
      output seed_value,
      output in_valid,
      output mode,
      output din,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  dout,
      input  state_out,
      input  beat_cnt
   );

   modport slave (
      input  seed_load,
      input  seed_value,
      input  in_valid,
      input  mode,
      input  din,
      input  out_ready,
      output in_ready,
      output out_valid,
      output dout,
      output state_out,
      output beat_cnt
   );
endinterface

// File: rtl/lfsr_stream_scrambler.sv
// Registered Galois-LFSR stream scrambler: each accepted beat advances the state DATA_W serial
// steps (scramble / descramble / additive per beat) behind a valid/ready output register.
module lfsr_stream_scrambler #(
   parameter int                 STATE_W  = 347,
   parameter int                 DATA_W   = 11,
   parameter logic [STATE_W-1:0] TAP_MASK = (STATE_W'(1) << 31)  | (STATE_W'(1) << 64) |
                                            (STATE_W'(1) << 162) | (STATE_W'(1) << 209) |
                                            (STATE_W'(1) << 236),
   parameter logic [STATE_W-1:0] SEED     = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   lfsr_stream_scrambler_if.slave bus
);
   logic [STATE_W-1:0] state_reg;
   logic [STATE_W-1:0] state_next;
   logic [DATA_W-1:0]  dout_reg;
   logic [DATA_W-1:0]  dout_next;
   logic               out_valid_reg;
   logic [31:0]        beat_cnt_reg;
   logic               in_ready;
   logic               accept;
   logic [STATE_W-1:0] tap_fb;

   // Bit 0 is always fed by the mode-selected feedback, so its mask bit is dropped.
   assign tap_fb   = {TAP_MASK[STATE_W-1:1], 1'b0};
   assign in_ready = !bus.seed_load && (!out_valid_reg || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      logic [STATE_W-1:0] s;
      logic               msb;
      logic               feed;
      s         = state_reg;
      dout_next = '0;
      msb       = 1'b0;
      feed      = 1'b0;
      for (int k = 0; k < DATA_W; k++) begin
         msb          = s[STATE_W-1];
         dout_next[k] = bus.din[k] ^ msb;
         case (bus.mode)
            2'd1:    feed = bus.din[k];
            2'd2:    feed = msb;
            default: feed = dout_next[k];
         endcase
         s = {s[STATE_W-2:0], feed} ^ (tap_fb & {STATE_W{msb}});
      end
      state_next = s;
   end

   // Seed load takes priority; in_ready is already low then, so no beat can be lost.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= SEED;
         beat_cnt_reg <= '0;
      end else if (bus.seed_load) begin
         state_reg    <= bus.seed_value;
         beat_cnt_reg <= '0;
      end else if (accept) begin
         state_reg    <= state_next;
         beat_cnt_reg <= beat_cnt_reg + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_reg      <= '0;
         out_valid_reg <= 1'b0;
      end else if (accept) begin
         dout_reg      <= dout_next;
         out_valid_reg <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_reg;
   assign bus.dout      = dout_reg;
   assign bus.state_out = state_reg;
   assign bus.beat_cnt  = beat_cnt_reg;
endmodule

// File: tb/tb_lfsr_stream_scrambler.sv
// Directed bench: small hand-computed config, default config against a bit-serial model,
// scramble/descramble and additive loopback, backpressure, seed collision and async reset.
module tb_lfsr_stream_scrambler;
   logic clk;
   logic rst;

   int n_tests;
   int n_fail;

   logic [346:0] tap;
   logic [346:0] seed5a;
   logic [346:0] m_state;
   logic [10:0]  m_out;

   lfsr_stream_scrambler_if #(.STATE_W(4),   .DATA_W(4))  bus_s ();
   lfsr_stream_scrambler_if #(.STATE_W(347), .DATA_W(11)) bus_a ();
   lfsr_stream_scrambler_if #(.STATE_W(347), .DATA_W(11)) bus_b ();

   lfsr_stream_scrambler #(
      .STATE_W(4), .DATA_W(4), .TAP_MASK(4'b0010), .SEED(4'b0000)
   ) dut_s (
      .clk(clk), .rst(rst), .bus(bus_s)
   );

   lfsr_stream_scrambler dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   lfsr_stream_scrambler dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Bit-serial reference: one index-level step at a time over the whole register.
   function automatic void model_beat(input logic [346:0] s_in, input logic [10:0] d,
                                      input logic [1:0] m, output logic [346:0] s_out,
                                      output logic [10:0] o);
      logic [346:0] s;
      logic [346:0] n;
      logic         msb;
      s = s_in;
      o = '0;
      for (int k = 0; k < 11; k++) begin
         msb  = s[346];
         o[k] = d[k] ^ msb;
         for (int i = 346; i >= 1; i--) n[i] = s[i-1] ^ (tap[i] & msb);
         if (m == 2'd1)      n[0] = d[k];
         else if (m == 2'd2) n[0] = msb;
         else                n[0] = o[k];
         s = n;
      end
      s_out = s;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus_a.out_valid); end
      n_tests++; if (bus_a.state_out !== 347'd0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", bus_a.state_out); end
      n_tests++; if (bus_a.beat_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d expected 0", bus_a.beat_cnt); end
      n_tests++; if (bus_a.dout !== 11'd0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", bus_a.dout); end
      n_tests++; if (bus_a.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus_a.in_ready); end
      bus_a.in_valid = 1'b1;
      tick;
      n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b expected 0", bus_a.out_valid); end
      n_tests++; if (bus_s.state_out !== 4'd0) begin n_fail++; $display("FAIL reset_small_state: got %h expected 0", bus_s.state_out); end
      bus_a.in_valid = 1'b0;
      #2 rst = 1'b1;
      tick;
   endtask

   task automatic test_small;
      bus_s.seed_load  = 1'b1;
      bus_s.seed_value = 4'b1000;
      bus_s.in_valid   = 1'b1;
      #1;
      n_tests++; if (bus_s.in_ready !== 1'b0) begin n_fail++; $display("FAIL small_seed_in_ready: got %b expected 0", bus_s.in_ready); end
      tick;
      bus_s.seed_load = 1'b0;
      bus_s.in_valid  = 1'b0;
      n_tests++; if (bus_s.state_out !== 4'b1000) begin n_fail++; $display("FAIL small_seed_state: got %b expected 1000", bus_s.state_out); end
      n_tests++; if (bus_s.beat_cnt !== 32'd0) begin n_fail++; $display("FAIL small_seed_cnt: got %0d expected 0", bus_s.beat_cnt); end
      bus_s.in_valid = 1'b1;
      bus_s.mode     = 2'd2;
      bus_s.din      = 4'b0000;
      tick;
      bus_s.in_valid = 1'b0;
      n_tests++; if (bus_s.dout !== 4'b1001) begin n_fail++; $display("FAIL small_dout: got %b expected 1001", bus_s.dout); end
      n_tests++; if (bus_s.state_out !== 4'b1011) begin n_fail++; $display("FAIL small_state: got %b expected 1011", bus_s.state_out); end
      n_tests++; if (bus_s.beat_cnt !== 32'd1) begin n_fail++; $display("FAIL small_cnt: got %0d expected 1", bus_s.beat_cnt); end
      n_tests++; if (bus_s.out_valid !== 1'b1) begin n_fail++; $display("FAIL small_valid: got %b expected 1", bus_s.out_valid); end
      tick;
      n_tests++; if (bus_s.out_valid !== 1'b0) begin n_fail++; $display("FAIL small_drain: got %b expected 0", bus_s.out_valid); end
      n_tests++; if (bus_s.dout !== 4'b1001) begin n_fail++; $display("FAIL small_dout_hold: got %b expected 1001", bus_s.dout); end
      $display("[TB] small config: dout=%b state=%b", bus_s.dout, bus_s.state_out);
   endtask

   task automatic test_model;
      logic [10:0] x;
      m_state       = 347'd0;
      bus_a.mode    = 2'd0;
      bus_a.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         x         = 11'($urandom);
         bus_a.din = x;
         model_beat(m_state, x, 2'd0, m_state, m_out);
         tick;
         n_tests++; if (bus_a.dout !== m_out) begin n_fail++; $display("FAIL model_dout[%0d]: got %h expected %h", i, bus_a.dout, m_out); end
         n_tests++; if (bus_a.state_out !== m_state) begin n_fail++; $display("FAIL model_state[%0d]: got %h expected %h", i, bus_a.state_out, m_state); end
      end
      bus_a.in_valid = 1'b0;
      n_tests++; if (bus_a.beat_cnt !== 32'd200) begin n_fail++; $display("FAIL model_cnt: got %0d expected 200", bus_a.beat_cnt); end
      $display("[TB] model: 200 beats mode 0, beat_cnt=%0d", bus_a.beat_cnt);
      tick;
   endtask

   task automatic test_loopback(input logic [1:0] ma, input logic [1:0] mb);
      logic [10:0] x;
      logic [10:0] x_prev;
      logic [10:0] a_prev;
      int          errs;
      errs = 0;
      x = '0; x_prev = '0; a_prev = '0;
      bus_a.seed_load = 1'b1; bus_a.seed_value = seed5a;
      bus_b.seed_load = 1'b1; bus_b.seed_value = seed5a;
      tick;
      bus_a.seed_load = 1'b0;
      bus_b.seed_load = 1'b0;
      n_tests++; if (bus_b.state_out !== seed5a) begin n_fail++; $display("FAIL loop_seed_b: got %h expected %h", bus_b.state_out, seed5a); end
      bus_a.mode = ma;
      bus_b.mode = mb;
      for (int i = 0; i <= 1000; i++) begin
         if (i < 1000) begin
            x              = 11'($urandom);
            bus_a.din      = x;
            bus_a.in_valid = 1'b1;
         end else begin
            bus_a.in_valid = 1'b0;
         end
         bus_b.in_valid = (i > 0);
         bus_b.din      = a_prev;
         tick;
         if (i > 0) begin
            n_tests++;
            if (bus_b.dout !== x_prev) begin
               n_fail++; errs++;
               $display("FAIL loop_m%0d_beat[%0d]: got %h expected %h", ma, i - 1, bus_b.dout, x_prev);
            end
         end
         a_prev = bus_a.dout;
         x_prev = x;
      end
      bus_b.in_valid = 1'b0;
      $display("[TB] loopback mode %0d->%0d: 1000 beats, %0d errors", ma, mb, errs);
      tick;
   endtask

   task automatic test_backpressure;
      logic [10:0]  v [4];
      logic [10:0]  hold_dout;
      logic [346:0] hold_state;
      for (int j = 0; j < 4; j++) v[j] = 11'($urandom);
      bus_a.seed_load = 1'b1; bus_a.seed_value = seed5a;
      tick;
      bus_a.seed_load = 1'b0;
      m_state         = seed5a;
      bus_a.mode      = 2'd0;
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.din       = v[0];
      model_beat(m_state, v[0], 2'd0, m_state, m_out);
      tick;
      n_tests++; if (bus_a.dout !== m_out) begin n_fail++; $display("FAIL bp_first_dout: got %h expected %h", bus_a.dout, m_out); end
      n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", bus_a.in_ready); end
      hold_dout  = m_out;
      hold_state = m_state;
      bus_a.din  = v[1];
      for (int c = 0; c < 4; c++) begin
         tick;
         n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", c, bus_a.in_ready); end
         n_tests++; if (bus_a.dout !== hold_dout) begin n_fail++; $display("FAIL bp_stall_dout[%0d]: got %h expected %h", c, bus_a.dout, hold_dout); end
         n_tests++; if (bus_a.state_out !== hold_state) begin n_fail++; $display("FAIL bp_stall_state[%0d]: got %h expected %h", c, bus_a.state_out, hold_state); end
         n_tests++; if (bus_a.beat_cnt !== 32'd1) begin n_fail++; $display("FAIL bp_stall_cnt[%0d]: got %0d expected 1", c, bus_a.beat_cnt); end
      end
      bus_a.out_ready = 1'b1;
      for (int j = 1; j < 4; j++) begin
         bus_a.din = v[j];
         model_beat(m_state, v[j], 2'd0, m_state, m_out);
         tick;
         n_tests++; if (bus_a.dout !== m_out) begin n_fail++; $display("FAIL bp_resume_dout[%0d]: got %h expected %h", j, bus_a.dout, m_out); end
         n_tests++; if (bus_a.beat_cnt !== 32'(j + 1)) begin n_fail++; $display("FAIL bp_resume_cnt[%0d]: got %0d expected %0d", j, bus_a.beat_cnt, j + 1); end
         n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume_valid[%0d]: got %b expected 1", j, bus_a.out_valid); end
      end
      bus_a.in_valid = 1'b0;
      tick;
      n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", bus_a.out_valid); end
      $display("[TB] backpressure: beat_cnt=%0d after stall and resume", bus_a.beat_cnt);
   endtask

   task automatic test_seed_collision;
      logic [10:0]  v0;
      logic [10:0]  v1;
      logic [10:0]  pend;
      logic [346:0] s2;
      v0 = 11'($urandom);
      v1 = 11'($urandom);
      s2 = ~seed5a;
      bus_a.mode      = 2'd0;
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.din       = v0;
      model_beat(m_state, v0, 2'd0, m_state, pend);
      tick;
      bus_a.seed_load  = 1'b1;
      bus_a.seed_value = s2;
      bus_a.din        = v1;
      #1;
      n_tests++; if (bus_a.in_ready !== 1'b0) begin n_fail++; $display("FAIL seed_in_ready: got %b expected 0", bus_a.in_ready); end
      tick;
      bus_a.seed_load = 1'b0;
      n_tests++; if (bus_a.state_out !== s2) begin n_fail++; $display("FAIL seed_state: got %h expected %h", bus_a.state_out, s2); end
      n_tests++; if (bus_a.beat_cnt !== 32'd0) begin n_fail++; $display("FAIL seed_cnt: got %0d expected 0", bus_a.beat_cnt); end
      n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL seed_pending_valid: got %b expected 1", bus_a.out_valid); end
      n_tests++; if (bus_a.dout !== pend) begin n_fail++; $display("FAIL seed_pending_dout: got %h expected %h", bus_a.dout, pend); end
      bus_a.out_ready = 1'b1;
      model_beat(s2, v1, 2'd0, m_state, m_out);
      tick;
      bus_a.in_valid = 1'b0;
      n_tests++; if (bus_a.dout !== m_out) begin n_fail++; $display("FAIL seed_next_dout: got %h expected %h", bus_a.dout, m_out); end
      n_tests++; if (bus_a.state_out !== m_state) begin n_fail++; $display("FAIL seed_next_state: got %h expected %h", bus_a.state_out, m_state); end
      n_tests++; if (bus_a.beat_cnt !== 32'd1) begin n_fail++; $display("FAIL seed_next_cnt: got %0d expected 1", bus_a.beat_cnt); end
      $display("[TB] seed collision: pending dout=%h, new beat dout=%h", pend, bus_a.dout);
      tick;
   endtask

   task automatic test_async_reset;
      logic [10:0] v;
      v = 11'($urandom);
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.din       = 11'($urandom);
      tick;
      bus_a.in_valid = 1'b0;
      n_tests++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", bus_a.out_valid); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", bus_a.out_valid); end
      n_tests++; if (bus_a.state_out !== 347'd0) begin n_fail++; $display("FAIL arst_state: got %h expected 0", bus_a.state_out); end
      n_tests++; if (bus_a.beat_cnt !== 32'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d expected 0", bus_a.beat_cnt); end
      n_tests++; if (bus_a.dout !== 11'd0) begin n_fail++; $display("FAIL arst_dout: got %h expected 0", bus_a.dout); end
      #2 rst = 1'b1;
      bus_a.out_ready = 1'b1;
      bus_a.in_valid  = 1'b1;
      bus_a.din       = v;
      model_beat(347'd0, v, 2'd0, m_state, m_out);
      tick;
      bus_a.in_valid = 1'b0;
      n_tests++; if (bus_a.dout !== m_out) begin n_fail++; $display("FAIL arst_post_dout: got %h expected %h", bus_a.dout, m_out); end
      n_tests++; if (bus_a.state_out !== m_state) begin n_fail++; $display("FAIL arst_post_state: got %h expected %h", bus_a.state_out, m_state); end
      n_tests++; if (bus_a.beat_cnt !== 32'd1) begin n_fail++; $display("FAIL arst_post_cnt: got %0d expected 1", bus_a.beat_cnt); end
      $display("[TB] async reset: post-reset dout=%h", bus_a.dout);
      tick;
   endtask

   initial begin
      logic [351:0] pat;
      n_tests = 0;
      n_fail  = 0;
      tap = '0;
      tap[31] = 1'b1; tap[64] = 1'b1; tap[162] = 1'b1; tap[209] = 1'b1; tap[236] = 1'b1;
      pat    = {44{8'h5A}};
      seed5a = pat[346:0];
      m_state = '0;
      m_out   = '0;

      bus_s.seed_load = 1'b0; bus_s.seed_value = '0; bus_s.in_valid = 1'b0;
      bus_s.mode = 2'd0; bus_s.din = '0; bus_s.out_ready = 1'b1;
      bus_a.seed_load = 1'b0; bus_a.seed_value = '0; bus_a.in_valid = 1'b0;
      bus_a.mode = 2'd0; bus_a.din = '0; bus_a.out_ready = 1'b1;
      bus_b.seed_load = 1'b0; bus_b.seed_value = '0; bus_b.in_valid = 1'b0;
      bus_b.mode = 2'd0; bus_b.din = '0; bus_b.out_ready = 1'b1;

      test_reset();
      test_small();
      test_model();
      test_loopback(2'd0, 2'd1);
      test_loopback(2'd2, 2'd2);
      test_backpressure();
      test_seed_collision();
      test_async_reset();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
